// File: rtl/multi_channel_process.sv
// Multi-channel audio frame processor: per-channel gain/mute/saturation plus per-band mixing.
// A frame is snapshotted on ready, then one channel is processed per cycle before outputs update.
module multi_channel_process #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned WIDTH = 18,
  parameter int unsigned BANDS = 7,
  parameter int unsigned BW    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  input  logic [NCH*WIDTH-1:0]    audio_in,
  input  logic [NCH*BANDS*BW-1:0] band_in,
  input  logic [NCH*8-1:0]        gain,
  input  logic [NCH-1:0]          mute,
  input  logic [1:0]              mix_mode,
  output logic [NCH*WIDTH-1:0]    audio_out,
  output logic [BANDS*BW-1:0]     band_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned Lg2Nch = $clog2(NCH);
  localparam int unsigned CntW   = (NCH > 1) ? Lg2Nch : 1;
  localparam int unsigned AccW   = BW + Lg2Nch;
  localparam int unsigned ProdW  = WIDTH + 9;
  localparam logic [CntW-1:0]  LastCh = CntW'(NCH - 1);
  localparam logic [WIDTH-1:0] MaxS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinS   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0] ModeAvg    = 2'b00;
  localparam logic [1:0] ModeMax    = 2'b01;
  localparam logic [1:0] ModeBypass = 2'b11;

  typedef enum logic [1:0] {StIdle, StProc, StFinal} state_e;

  state_e                                 state_q, state_d;
  logic [CntW-1:0]                        cnt_q, cnt_d;
  logic [NCH-1:0][WIDTH-1:0]              audio_s_q, audio_s_d;
  logic [NCH-1:0][BANDS-1:0][BW-1:0]      band_s_q, band_s_d;
  logic [NCH-1:0][7:0]                    gain_s_q, gain_s_d;
  logic [NCH-1:0]                         mute_s_q, mute_s_d;
  logic [1:0]                             mode_s_q, mode_s_d;
  logic [BANDS-1:0][AccW-1:0]             acc_q, acc_d;
  logic [NCH-1:0][WIDTH-1:0]              res_q, res_d;
  logic [NCH-1:0][WIDTH-1:0]              audio_out_q, audio_out_d;
  logic [BANDS-1:0][BW-1:0]               band_out_q, band_out_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   busy_q, busy_d;
  logic                                   overrun_q, overrun_d;

  logic signed [WIDTH-1:0] x;
  logic signed [ProdW-1:0] prod, shifted;
  logic [WIDTH-1:0]        y;
  logic [BW-1:0]           bv;
  logic [AccW-1:0]         contrib, avg;

  // Sample path for the channel currently selected by the counter.
  always_comb begin
    x       = $signed(audio_s_q[cnt_q]);
    prod    = $signed({{9{x[WIDTH-1]}}, x}) * $signed({{(WIDTH+1){1'b0}}, gain_s_q[cnt_q]});
    shifted = prod >>> 4;
    if (mode_s_q == ModeBypass) begin
      y = x;
    end else if (mute_s_q[cnt_q]) begin
      y = '0;
    end else if (shifted[ProdW-1:WIDTH-1] != {(ProdW-WIDTH+1){shifted[ProdW-1]}}) begin
      y = shifted[ProdW-1] ? MinS : MaxS;
    end else begin
      y = shifted[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    audio_s_d   = audio_s_q;
    band_s_d    = band_s_q;
    gain_s_d    = gain_s_q;
    mute_s_d    = mute_s_q;
    mode_s_d    = mode_s_q;
    acc_d       = acc_q;
    res_d       = res_q;
    audio_out_d = audio_out_q;
    band_out_d  = band_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    bv          = '0;
    contrib     = '0;
    avg         = '0;

    unique case (state_q)
      StIdle: begin
        if (ready) begin
          audio_s_d = audio_in;
          band_s_d  = band_in;
          gain_s_d  = gain;
          mute_s_d  = mute;
          mode_s_d  = mix_mode;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = StProc;
        end
      end
      StProc: begin
        res_d[cnt_q] = y;
        for (int b = 0; b < BANDS; b++) begin
          bv      = band_s_q[cnt_q][b];
          contrib = mute_s_q[cnt_q] ? '0 : AccW'(bv);
          case (mode_s_q)
            ModeAvg: acc_d[b] = acc_q[b] + contrib;
            ModeMax: if (contrib > acc_q[b]) acc_d[b] = contrib;
            // Channel-0-only and bypass modes take channel 0 bands regardless of mute.
            default: if (cnt_q == '0) acc_d[b] = AccW'(bv);
          endcase
        end
        if (cnt_q == LastCh) begin
          state_d = StFinal;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFinal: begin
        audio_out_d = res_q;
        for (int b = 0; b < BANDS; b++) begin
          avg           = acc_q[b] >> Lg2Nch;
          band_out_d[b] = (mode_s_q == ModeAvg) ? avg[BW-1:0] : acc_q[b][BW-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (ready && (state_q != StIdle)) overrun_d = 1'b1;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      audio_s_q   <= '0;
      band_s_q    <= '0;
      gain_s_q    <= '0;
      mute_s_q    <= '0;
      mode_s_q    <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      audio_out_q <= '0;
      band_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      audio_s_q   <= audio_s_d;
      band_s_q    <= band_s_d;
      gain_s_q    <= gain_s_d;
      mute_s_q    <= mute_s_d;
      mode_s_q    <= mode_s_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      audio_out_q <= audio_out_d;
      band_out_q  <= band_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign audio_out = audio_out_q;
  assign band_out  = band_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/multi_channel_process.md
MULTI_CHANNEL_PROCESS -- requirements
Module: multi_channel_process

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): NCH, 2, channel count (power of two, 1..16).
REQ-002 The block SHALL have parameter WIDTH, 18, signed audio sample width.
REQ-003 The block SHALL have parameter BANDS, 7, frequency bands per channel.
REQ-004 The block SHALL have parameter BW, 8, unsigned band-magnitude width.
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset; the ports are listed below.
REQ-006 The block SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port ready, input, 1, one-cycle new-sample strobe.
REQ-009 The block SHALL have port audio_in, input, NCH*WIDTH, signed samples; channel k at [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port band_in, input, NCH*BANDS*BW, band magnitudes; channel k, band b at [(k*BANDS+b)*BW +: BW].
REQ-011 The block SHALL have port gain, input, NCH*8, per-channel unsigned Q4.4 gain; 8'h10 means unity.
REQ-012 The block SHALL have port mute, input, NCH, per-channel mute.
REQ-013 The block SHALL have port mix_mode, input, 2, band mix mode: 00 average, 01 maximum, 10 channel 0 only, 11 bypass.
REQ-014 The block SHALL have port audio_out, output, NCH*WIDTH, processed samples, packed like audio_in.
REQ-015 The block SHALL have port band_out, output, BANDS*BW, mixed band magnitudes, packed by band.
REQ-016 The block SHALL have port out_valid, output, 1, one-cycle pulse when the outputs update.
REQ-017 The block SHALL have port busy, output, 1, high while a frame is in flight.
REQ-018 The block SHALL have port overrun, output, 1, sticky flag set when ready arrives while busy.

Function
REQ-019 The FSM SHALL have states IDLE, PROC and FINAL; reset forces IDLE.
REQ-020 In IDLE, ready=1 SHALL snapshot audio_in, band_in, gain, mute and mix_mode into internal registers, clear the band accumulators, set the channel counter to 0 and move to PROC.
REQ-021 PROC SHALL handle exactly one channel per cycle, in order 0..NCH-1, using snapshot values only; after channel NCH-1 the FSM SHALL move to FINAL.
REQ-022 Sample path, modes 00/01/10: y = (x * gain), a signed WIDTH+9-bit product, arithmetic-shifted right 4 (floor), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-023 A muted channel SHALL output 0 in modes 00/01/10.
REQ-024 Mode 11 (bypass) SHALL pass samples unchanged and ignore gain and mute.
REQ-025 Band path, mode 00: per band, sum channels into a BW+log2(NCH)-bit accumulator and take the result as sum >> log2(NCH), truncated.
REQ-026 Band path, mode 01: per band, take the running maximum across channels.
REQ-027 Band path, modes 10 and 11: take channel 0 band values, with mute ignored.
REQ-028 Muted channels SHALL contribute 0 to the band path in modes 00 and 01.
REQ-029 FINAL SHALL load audio_out and band_out together, pulse out_valid for one cycle and return to IDLE.
REQ-030 Latency: ready sampled at edge t SHALL give out_valid high in the cycle after edge t+NCH+1, i.e. NCH+2 cycles.
REQ-031 Between out_valid pulses, audio_out and band_out SHALL hold their values.
REQ-032 busy SHALL be high in PROC and FINAL and low in IDLE.
REQ-033 ready while busy (PROC or FINAL) SHALL be ignored and SHALL set overrun, which stays set until reset.
REQ-034 The in-flight frame SHALL be unaffected by an ignored ready.
REQ-035 ready in the IDLE cycle immediately after FINAL SHALL be accepted, giving back-to-back frames with no overrun.
REQ-036 Input changes during PROC SHALL have no effect on the current frame.

Reset
REQ-037 Reset SHALL force FSM=IDLE and set audio_out=0, band_out=0, out_valid=0, busy=0, overrun=0, all snapshot registers and accumulators to 0.
REQ-038 Reset SHALL take priority over ready in the same cycle.
REQ-039 Reset mid-frame SHALL abort the frame with no out_valid for it; ready is accepted on the first cycle after reset deasserts.

Verification (NCH=2, WIDTH=18, BANDS=7, BW=8)
REQ-040 Unity gain: x0=1000, x1=-1000, gain=8'h10, mode 00, ready at t -> out_valid at t+4, outputs 1000/-1000, busy high for cycles t+1..t+3.
REQ-041 Gain and saturation: x0=100000 with gain 8'h20 -> 131071; x1=-100000 with gain 8'h20 -> -131072; x0=3 with gain 8'h08 -> 1; x0=-3 with gain 8'h08 -> -2.
REQ-042 Band modes: band1 ch0=200, ch1=100 -> mode 00 gives 150, 01 gives 200, 10 gives 200; ch1 muted in mode 00 -> 100.
REQ-043 Overrun: ready at t and t+2 -> exactly one out_valid at t+4, overrun=1 from t+3 and held; ready at t and t+4 -> two frames, overrun=0.
REQ-044 Bypass and mute: mode 11, mute=2'b11, gain=0, x0=-5 -> audio_out ch0=-5; mode 00 with the same inputs -> 0.
REQ-045 Reset mid-frame: reset at t+2 -> no out_valid at t+4, all outputs 0; new ready after reset -> normal result NCH+2 cycles later.
